// File: rtl/rv32_multicycle_core_if.sv
// Instruction fetch port: core raises req with a stable addr; memory answers with valid plus the word.
// Latency is set by memory. The core holds req and addr until valid, so memory stalls by withholding valid.
interface rv32_multicycle_core_if;
  logic        mem_program_req;
  logic [31:0] mem_program_addr_bus;
  logic        mem_program_valid;
  logic [31:0] mem_program_data_bus;

  modport master (
    output mem_program_req,
    output mem_program_addr_bus,
    input  mem_program_valid,
    input  mem_program_data_bus
  );

  modport slave (
    input  mem_program_req,
    input  mem_program_addr_bus,
    output mem_program_valid,
    output mem_program_data_bus
  );
endinterface

// File: rtl/rv32_multicycle_core.sv
// Multicycle RV32I/RV32E integer core (no loads/stores). Each instruction takes at least 4 cycles.
// A fetch stalls in ST_FETCH until valid arrives, adding 1 cycle per wait cycle. Traps and ECALL/EBREAK park the core in ST_HALT.
module rv32_multicycle_core #(
  parameter int          NUM_REGS = 16,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                   clk,
  input  logic                   reset,
  rv32_multicycle_core_if.master mem,
  output logic                   retire,
  output logic                   halted,
  output logic                   illegal_inst
);
  localparam int AW = (NUM_REGS > 16) ? 5 : 4;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  typedef enum logic [4:0] {
    ST_FETCH      = 5'b00001,
    ST_DECODE     = 5'b00010,
    ST_EXECUTE    = 5'b00100,
    ST_WRITE_BACK = 5'b01000,
    ST_HALT       = 5'b10000
  } state_t;

  state_t      state, state_n;
  logic [31:0] pc, inst, op_a, op_b, imm_q, result_q, next_pc_q;
  logic [31:0] regs [NUM_REGS];
  logic        fetch_req, wb_pulse;

  logic [6:0]  opcode, f7;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  f3;
  logic [31:0] imm_i, imm_b, imm_u, imm_j, dec_imm, rs1_val, rs2_val;
  logic        dec_legal, dec_sys;

  assign opcode = inst[6:0];
  assign rd     = inst[11:7];
  assign f3     = inst[14:12];
  assign rs1    = inst[19:15];
  assign rs2    = inst[24:20];
  assign f7     = inst[31:25];
  assign imm_i  = {{20{inst[31]}}, inst[31:20]};
  assign imm_b  = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
  assign imm_u  = {inst[31:12], 12'b0};
  assign imm_j  = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
  assign rs1_val = (rs1 == 5'd0) ? 32'd0 : regs[rs1[AW-1:0]];
  assign rs2_val = (rs2 == 5'd0) ? 32'd0 : regs[rs2[AW-1:0]];
  assign dec_sys = (opcode == OPC_SYSTEM);

  function automatic logic idx_ok(logic [4:0] idx);
    return int'(idx) < NUM_REGS;
  endfunction

  always_comb begin
    dec_legal = 1'b0;
    dec_imm   = imm_i;
    case (opcode)
      OPC_OP:     dec_legal = (f7 == 7'b0 || (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101)))
                              && idx_ok(rd) && idx_ok(rs1) && idx_ok(rs2);
      // shift-immediates carry funct7 in imm[11:5]; imm[5]=1 is a 64-bit shift and is rejected here
      OPC_OPIMM: begin
        dec_legal = idx_ok(rd) && idx_ok(rs1);
        if (f3 == 3'b001) dec_legal = dec_legal && (f7 == 7'b0);
        if (f3 == 3'b101) dec_legal = dec_legal && (f7 == 7'b0 || f7 == 7'b0100000);
      end
      OPC_LUI, OPC_AUIPC: begin dec_legal = idx_ok(rd); dec_imm = imm_u; end
      OPC_JAL:    begin dec_legal = idx_ok(rd); dec_imm = imm_j; end
      OPC_JALR:   dec_legal = (f3 == 3'b000) && idx_ok(rd) && idx_ok(rs1);
      OPC_BRANCH: begin
        dec_legal = (f3 != 3'b010) && (f3 != 3'b011) && idx_ok(rs1) && idx_ok(rs2);
        dec_imm   = imm_b;
      end
      default:    dec_legal = 1'b0;
    endcase
  end

  logic [31:0] alu_b, alu_out, ex_res, ex_npc;
  logic [4:0]  shamt;
  logic        br_take, ex_jump, ex_misal;

  assign alu_b = (opcode == OPC_OPIMM) ? imm_q : op_b;
  assign shamt = alu_b[4:0];

  always_comb begin
    case (f3)
      3'b000:  alu_out = (opcode == OPC_OP && inst[30]) ? op_a - alu_b : op_a + alu_b;
      3'b001:  alu_out = op_a << shamt;
      3'b010:  alu_out = {31'b0, $signed(op_a) < $signed(alu_b)};
      3'b011:  alu_out = {31'b0, op_a < alu_b};
      3'b100:  alu_out = op_a ^ alu_b;
      3'b101:  alu_out = inst[30] ? 32'($signed(op_a) >>> shamt) : op_a >> shamt;
      3'b110:  alu_out = op_a | alu_b;
      default: alu_out = op_a & alu_b;
    endcase
    case (f3)
      3'b000:  br_take = (op_a == op_b);
      3'b001:  br_take = (op_a != op_b);
      3'b100:  br_take = $signed(op_a) < $signed(op_b);
      3'b101:  br_take = $signed(op_a) >= $signed(op_b);
      3'b110:  br_take = op_a < op_b;
      3'b111:  br_take = op_a >= op_b;
      default: br_take = 1'b0;
    endcase
  end

  always_comb begin
    ex_res  = alu_out;
    ex_npc  = pc + 32'd4;
    ex_jump = 1'b0;
    case (opcode)
      OPC_LUI:    ex_res = imm_q;
      OPC_AUIPC:  ex_res = pc + imm_q;
      OPC_JAL:    begin ex_res = pc + 32'd4; ex_npc = pc + imm_q; ex_jump = 1'b1; end
      OPC_JALR:   begin ex_res = pc + 32'd4; ex_npc = (op_a + imm_q) & ~32'd1; ex_jump = 1'b1; end
      OPC_BRANCH: if (br_take) begin ex_npc = pc + imm_q; ex_jump = 1'b1; end
      default:    ;
    endcase
    ex_misal = ex_jump && ex_npc[1];
  end

  always_ff @(posedge clk) begin
    if (reset) state <= ST_FETCH;
    else       state <= state_n;
  end

  always_comb begin
    state_n   = state;
    fetch_req = 1'b0;
    wb_pulse  = 1'b0;
    case (state)
      ST_FETCH: begin
        fetch_req = 1'b1;
        if (mem.mem_program_valid) state_n = ST_DECODE;
      end
      ST_DECODE:     state_n = (dec_sys || !dec_legal) ? ST_HALT : ST_EXECUTE;
      ST_EXECUTE:    state_n = ex_misal ? ST_HALT : ST_WRITE_BACK;
      ST_WRITE_BACK: begin wb_pulse = 1'b1; state_n = ST_FETCH; end
      ST_HALT:       state_n = ST_HALT;
      default:       state_n = ST_FETCH;
    endcase
  end

  // Gated by reset so the reset cycle itself shows idle outputs whatever state it interrupts
  assign mem.mem_program_req      = fetch_req & ~reset;
  assign mem.mem_program_addr_bus = pc;
  assign retire                   = wb_pulse & ~reset;
  assign halted                   = (state == ST_HALT);

  always_ff @(posedge clk) begin
    if (reset) begin
      pc           <= RESET_PC;
      inst         <= '0;
      op_a         <= '0;
      op_b         <= '0;
      imm_q        <= '0;
      result_q     <= '0;
      next_pc_q    <= '0;
      illegal_inst <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else begin
      case (state)
        ST_FETCH: if (mem.mem_program_valid) inst <= mem.mem_program_data_bus;
        ST_DECODE: begin
          op_a  <= rs1_val;
          op_b  <= rs2_val;
          imm_q <= dec_imm;
          if (!dec_sys && !dec_legal) illegal_inst <= 1'b1;
        end
        ST_EXECUTE: begin
          result_q  <= ex_res;
          next_pc_q <= ex_npc;
          if (ex_misal) illegal_inst <= 1'b1;
        end
        ST_WRITE_BACK: begin
          if (opcode != OPC_BRANCH && rd != 5'd0) regs[rd[AW-1:0]] <= result_q;
          pc <= next_pc_q;
        end
        default: ;
      endcase
    end
  end
endmodule
